// File: rtl/plic_ctrl_pkg.sv
// Shared types for the PLIC claim/complete controller: FSM state encoding and
// the in-service table entry.
package plic_ctrl_pkg;

  // Widest interrupt ID the table entry can hold; narrower IDs are zero-extended.
  localparam int ID_W_MAX = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    BLANK = 2'd2
  } claim_state_e;

  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } claim_entry_t;

endpackage

// File: rtl/plic_claim_table.sv
// In-service table: records claimed IDs until their completion arrives.
// Inserts take the lowest free slot, frees hit the lowest matching slot.
module plic_claim_table #(
  parameter int MAX_CLAIM = 4,
  parameter int ID_W      = 9
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            insert_i,
  input  logic [ID_W-1:0] insert_id_i,
  input  logic            free_i,
  input  logic [ID_W-1:0] free_id_i,
  output logic            match_o,
  output logic            full_o
);
  import plic_ctrl_pkg::*;

  claim_entry_t [MAX_CLAIM-1:0] tbl_q;
  claim_entry_t [MAX_CLAIM-1:0] tbl_d;
  logic [MAX_CLAIM-1:0]         vld_s;
  logic [MAX_CLAIM-1:0]         hit_s;
  logic [ID_W_MAX-1:0]          free_key_s;
  logic                         freed_s;
  logic                         placed_s;

  assign free_key_s = ID_W_MAX'(free_id_i);

  // Per-slot occupancy and match against the completion ID.
  always_comb begin
    vld_s = {MAX_CLAIM{1'b0}};
    hit_s = {MAX_CLAIM{1'b0}};
    for (int i = 0; i < MAX_CLAIM; i++) begin
      vld_s[i] = tbl_q[i].valid;
      hit_s[i] = tbl_q[i].valid && (tbl_q[i].id == free_key_s);
    end
  end

  assign match_o = |hit_s;
  assign full_o  = &vld_s;

  // Both slot choices look at the current table, so a slot freed this cycle
  // is never handed to a simultaneous insert.
  always_comb begin
    tbl_d    = tbl_q;
    freed_s  = 1'b0;
    placed_s = 1'b0;
    for (int i = 0; i < MAX_CLAIM; i++) begin
      if (free_i && hit_s[i] && !freed_s) begin
        tbl_d[i].valid = 1'b0;
        freed_s        = 1'b1;
      end else begin
        freed_s = freed_s;
      end
      if (insert_i && !full_o && !vld_s[i] && !placed_s) begin
        tbl_d[i].valid = 1'b1;
        tbl_d[i].id    = ID_W_MAX'(insert_id_i);
        placed_s       = 1'b1;
      end else begin
        placed_s = placed_s;
      end
    end
  end

  // Table state with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tbl_q <= {(MAX_CLAIM * $bits(claim_entry_t)){1'b0}};
    end else begin
      tbl_q <= tbl_d;
    end
  end

endmodule

// File: rtl/plic_claim_ctrl.sv
// PLIC target claim/complete controller: arbitrates hart claim reads against
// the arbitration-tree winner and tracks in-service IDs until completion.
module plic_claim_ctrl #(
  parameter int NUM_IRQ   = 512,
  parameter int PRIO_BIT  = 5,
  parameter int STAGING   = 1,
  parameter int MAX_CLAIM = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       arb_irq_i,
  input  logic [$clog2(NUM_IRQ)-1:0] arb_id_i,
  input  logic [PRIO_BIT-1:0]        arb_pri_i,
  input  logic                       claim_req_i,
  output logic                       claim_ack_o,
  output logic [$clog2(NUM_IRQ)-1:0] claim_id_o,
  input  logic                       cmpl_vld_i,
  input  logic [$clog2(NUM_IRQ)-1:0] cmpl_id_i,
  output logic                       pend_clr_o,
  output logic [$clog2(NUM_IRQ)-1:0] pend_clr_id_o,
  output logic                       gw_rel_o,
  output logic [$clog2(NUM_IRQ)-1:0] gw_rel_id_o,
  output logic                       eip_o
);
  import plic_ctrl_pkg::*;

  localparam int              ID_W  = $clog2(NUM_IRQ);
  localparam logic [ID_W-1:0] NO_ID = {ID_W{1'b0}};

  claim_state_e    state_q;
  logic [1:0]      cnt_q;
  logic [ID_W-1:0] cap_id_q;
  logic            claim_ack_q;
  logic [ID_W-1:0] claim_id_q;
  logic            pend_clr_q;
  logic [ID_W-1:0] pend_clr_id_q;
  logic            gw_rel_q;
  logic [ID_W-1:0] gw_rel_id_q;

  logic            full_s;
  logic            match_s;
  logic            insert_s;
  logic            free_s;
  logic            rel_s;
  logic [ID_W-1:0] win_id_s;
  logic            unused_pri_s;

  // Priority is already resolved by the upstream tree and only passes through here.
  assign unused_pri_s = ^arb_pri_i;

  assign win_id_s = (arb_irq_i && !full_s) ? arb_id_i : NO_ID;
  assign insert_s = (state_q == RESP) && (cap_id_q != NO_ID);
  assign free_s   = cmpl_vld_i && (cmpl_id_i != NO_ID);
  assign rel_s    = free_s && match_s;

  plic_claim_table #(
    .MAX_CLAIM (MAX_CLAIM),
    .ID_W      (ID_W)
  ) u_table (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .insert_i    (insert_s),
    .insert_id_i (cap_id_q),
    .free_i      (free_s),
    .free_id_i   (cmpl_id_i),
    .match_o     (match_s),
    .full_o      (full_s)
  );

  // Claim FSM with its registered response and release pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      cap_id_q      <= NO_ID;
      claim_ack_q   <= 1'b0;
      claim_id_q    <= NO_ID;
      pend_clr_q    <= 1'b0;
      pend_clr_id_q <= NO_ID;
      gw_rel_q      <= 1'b0;
      gw_rel_id_q   <= NO_ID;
    end else begin
      claim_ack_q   <= 1'b0;
      claim_id_q    <= NO_ID;
      pend_clr_q    <= 1'b0;
      pend_clr_id_q <= NO_ID;
      gw_rel_q      <= rel_s;
      gw_rel_id_q   <= rel_s ? cmpl_id_i : NO_ID;
      case (state_q)
        IDLE: begin
          if (claim_req_i) begin
            state_q       <= RESP;
            cap_id_q      <= win_id_s;
            claim_ack_q   <= 1'b1;
            claim_id_q    <= win_id_s;
            pend_clr_q    <= (win_id_s != NO_ID);
            pend_clr_id_q <= win_id_s;
          end else begin
            state_q <= IDLE;
          end
        end
        RESP: begin
          // BLANK hides the stale winner while the tree settles after the clear.
          if (cap_id_q != NO_ID) begin
            state_q <= BLANK;
            cnt_q   <= 2'(STAGING);
          end else begin
            state_q <= IDLE;
          end
          cap_id_q <= NO_ID;
        end
        BLANK: begin
          if (cnt_q == 2'd0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 2'd0;
        end
      endcase
    end
  end

  assign claim_ack_o   = claim_ack_q;
  assign claim_id_o    = claim_id_q;
  assign pend_clr_o    = pend_clr_q;
  assign pend_clr_id_o = pend_clr_id_q;
  assign gw_rel_o      = gw_rel_q;
  assign gw_rel_id_o   = gw_rel_id_q;
  assign eip_o         = rst_n_i && (state_q == IDLE) && arb_irq_i;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Bench for plic_claim_ctrl: directed scenarios plus random traffic, all checked
// against a transaction-level model of the claim/complete rules.
module tb_plic_claim_ctrl;
  localparam int NUM_IRQ   = 512;
  localparam int PRIO_BIT  = 5;
  localparam int STAGING   = 1;
  localparam int MAX_CLAIM = 4;
  localparam int ID_W      = $clog2(NUM_IRQ);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                arb_irq = 1'b0;
  logic [ID_W-1:0]     arb_id = '0;
  logic [PRIO_BIT-1:0] arb_pri = 5'd3;
  logic                claim_req = 1'b0;
  logic                claim_ack_o;
  logic [ID_W-1:0]     claim_id_o;
  logic                cmpl_vld = 1'b0;
  logic [ID_W-1:0]     cmpl_id = '0;
  logic                pend_clr_o;
  logic [ID_W-1:0]     pend_clr_id_o;
  logic                gw_rel_o;
  logic [ID_W-1:0]     gw_rel_id_o;
  logic                eip_o;

  always #5 clk = ~clk;

  plic_claim_ctrl #(
    .NUM_IRQ(NUM_IRQ), .PRIO_BIT(PRIO_BIT), .STAGING(STAGING), .MAX_CLAIM(MAX_CLAIM)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .arb_irq_i(arb_irq), .arb_id_i(arb_id),
    .arb_pri_i(arb_pri), .claim_req_i(claim_req), .claim_ack_o(claim_ack_o),
    .claim_id_o(claim_id_o), .cmpl_vld_i(cmpl_vld), .cmpl_id_i(cmpl_id),
    .pend_clr_o(pend_clr_o), .pend_clr_id_o(pend_clr_id_o), .gw_rel_o(gw_rel_o),
    .gw_rel_id_o(gw_rel_id_o), .eip_o(eip_o)
  );

  int total = 0;
  int bad   = 0;

  // Model: in-service IDs (0 = free slot), remaining busy cycles, pending insert.
  int m_tbl[MAX_CLAIM];
  int m_busy = 0;
  int m_pend_ins = 0;
  int e_ack = 0, e_cid = 0, e_pc = 0, e_pcid = 0, e_rel = 0, e_relid = 0;
  int last_eip = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int used;
    int free_idx;
    int ins_idx;
    int win;
    bit full_pre;
    e_ack = 0; e_cid = 0; e_pc = 0; e_pcid = 0; e_rel = 0; e_relid = 0;
    if (!rst_n) begin
      foreach (m_tbl[i]) m_tbl[i] = 0;
      m_busy = 0;
      m_pend_ins = 0;
      return;
    end
    used = 0;
    foreach (m_tbl[i]) if (m_tbl[i] != 0) used++;
    full_pre = (used == MAX_CLAIM);
    free_idx = -1;
    ins_idx  = -1;
    for (int i = MAX_CLAIM - 1; i >= 0; i--) begin
      if (cmpl_vld && cmpl_id != 0 && m_tbl[i] == int'(cmpl_id)) free_idx = i;
      if (m_tbl[i] == 0) ins_idx = i;
    end
    if (free_idx >= 0) begin
      e_rel = 1;
      e_relid = int'(cmpl_id);
      m_tbl[free_idx] = 0;
    end
    if (m_pend_ins != 0 && ins_idx >= 0) m_tbl[ins_idx] = m_pend_ins;
    m_pend_ins = 0;
    if (m_busy == 0 && claim_req) begin
      win = (arb_irq && !full_pre) ? int'(arb_id) : 0;
      e_ack = 1; e_cid = win; e_pc = (win != 0); e_pcid = win;
      m_pend_ins = win;
      m_busy = (win != 0) ? STAGING + 2 : 1;
    end else if (m_busy > 0) begin
      m_busy--;
    end
  endtask

  task automatic step(input bit r, input bit rq, input bit irq, input int aid,
                      input bit cv, input int cid);
    rst_n = r; claim_req = rq; arb_irq = irq; arb_id = ID_W'(aid);
    arb_pri = 5'($urandom_range(1, 31)); cmpl_vld = cv; cmpl_id = ID_W'(cid);
    #1;
    last_eip = int'(eip_o);
    check_val("eip", last_eip, (r && m_busy == 0 && irq) ? 1 : 0);
    @(posedge clk);
    model_edge();
    #1;
    check_val("ack", int'(claim_ack_o), e_ack);
    check_val("claim_id", int'(claim_id_o), e_cid);
    check_val("pend_clr", int'(pend_clr_o), e_pc);
    check_val("pend_clr_id", int'(pend_clr_id_o), e_pcid);
    check_val("gw_rel", int'(gw_rel_o), e_rel);
    check_val("gw_rel_id", int'(gw_rel_id_o), e_relid);
  endtask

  task automatic idle_wait();
    for (int i = 0; i < 8 && m_busy != 0; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic claim(input int id, output int got);
    step(1'b1, 1'b1, 1'b1, id, 1'b0, 0);
    got = int'(claim_id_o);
    idle_wait();
  endtask

  int got;
  int n;
  bit rq;
  int cid;

  initial begin
    foreach (m_tbl[i]) m_tbl[i] = 0;
    step(1'b0, 1'b0, 1'b1, 3, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 3, 1'b0, 0);
    check_val("rst_ack", int'(claim_ack_o), 0);

    // Winner 37 claimed, then eip held low through RESP and BLANK.
    step(1'b1, 1'b1, 1'b1, 37, 1'b0, 0);
    check_val("c37_ack", int'(claim_ack_o), 1);
    check_val("c37_id", int'(claim_id_o), 37);
    check_val("c37_pcid", int'(pend_clr_id_o), 37);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 40, 1'b0, 0);
      if (last_eip != 0) break;
      n++;
    end
    check_val("eip_blank_len", n, STAGING + 2);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 37);
    check_val("rel37", int'(gw_rel_id_o), 37);

    // No winner: ack with ID 0, idle again right after.
    step(1'b1, 1'b1, 1'b0, 12, 1'b0, 0);
    check_val("nowin_id", int'(claim_id_o), 0);
    check_val("nowin_pc", int'(pend_clr_o), 0);
    step(1'b1, 1'b0, 1'b1, 12, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 12, 1'b0, 0);
    check_val("nowin_idle", last_eip, 1);

    // Fill the table, overflow claim, complete 6 and retry.
    for (int k = 5; k <= 8; k++) begin
      claim(k, got);
      check_val("fill", got, k);
    end
    claim(9, got);
    check_val("full_id", got, 0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 6);
    check_val("rel6", int'(gw_rel_o), 1);
    check_val("rel6_id", int'(gw_rel_id_o), 6);
    claim(9, got);
    check_val("after_rel", got, 9);

    // Unknown and zero completions are ignored.
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 100);
    check_val("cmpl100", int'(gw_rel_o), 0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 0);
    check_val("cmpl0", int'(gw_rel_o), 0);
    claim(11, got);
    check_val("still_full", got, 0);

    // Full table: completion of 5 lands in the RESP cycle of a claim for 10.
    step(1'b1, 1'b1, 1'b1, 10, 1'b0, 0);
    check_val("race_id", int'(claim_id_o), 0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 5);
    check_val("race_rel", int'(gw_rel_id_o), 5);
    idle_wait();

    // Reset in BLANK aborts everything and empties the table.
    step(1'b1, 1'b1, 1'b1, 37, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 37, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 37, 1'b1, 9);
    check_val("rstb_out", int'({claim_ack_o, pend_clr_o, gw_rel_o, claim_id_o,
                                pend_clr_id_o, gw_rel_id_o}), 0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 9);
    check_val("rstb_empty", int'(gw_rel_o), 0);
    claim(37, got);
    check_val("regrant37", got, 37);

    // Random traffic; claim requests are held until acknowledged.
    rq = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!rq && $urandom_range(0, 2) == 0) rq = 1'b1;
      cid = ($urandom_range(0, 1) == 0) ? m_tbl[$urandom_range(0, MAX_CLAIM - 1)]
                                        : int'($urandom_range(0, 60));
      step(($urandom_range(0, 149) != 0), rq, ($urandom_range(0, 3) != 0),
           int'($urandom_range(1, 60)), ($urandom_range(0, 3) == 0), cid);
      if (e_ack != 0 || !rst_n) rq = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
